// File: rtl/nrisc_imem_loader_if.sv
// Bus bundle for nrisc_imem_loader: core fetch port plus programming/burst-load port.
// master = core/programmer side, slave = instruction memory side.
interface nrisc_imem_loader_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int CORE_AW = 16
);
    logic               core_req;
    logic [CORE_AW-1:0] core_addr;
    logic               core_stall;
    logic               core_valid;
    logic [DATA_W-1:0]  core_data;
    logic               core_err;

    logic               prog_start;
    logic [ADDR_W-1:0]  prog_base;
    logic [ADDR_W:0]    prog_len;
    logic               prog_wvalid;
    logic [DATA_W-1:0]  prog_wdata;
    logic               prog_wready;
    logic               prog_busy;
    logic               prog_done;
    logic [DATA_W-1:0]  prog_sum;

    modport master (
        output core_req, core_addr,
        input  core_stall, core_valid, core_data, core_err,
        output prog_start, prog_base, prog_len, prog_wvalid, prog_wdata,
        input  prog_wready, prog_busy, prog_done, prog_sum
    );

    modport slave (
        input  core_req, core_addr,
        output core_stall, core_valid, core_data, core_err,
        input  prog_start, prog_base, prog_len, prog_wvalid, prog_wdata,
        output prog_wready, prog_busy, prog_done, prog_sum
    );
endinterface

// File: rtl/nrisc_imem_loader.sv
// NRISC instruction memory with 1-cycle core fetch port and a burst-load programming FSM.
// Optional load checksum on prog_sum when NRISC_IMEM_CHECKSUM_EN is defined.
module nrisc_imem_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int CORE_AW = 16
) (
    input logic                clk,
    input logic                rst,
    nrisc_imem_loader_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    logic start_acc;
    logic wr_en;
    logic fetch_acc;
    logic addr_oor;

    assign start_acc = (state_q == S_IDLE) & bus.prog_start;
    // Writes are gated by reset so an aborted burst never lands a word on the reset edge.
    assign wr_en     = rst & (state_q == S_LOAD) & bus.prog_wvalid;
    assign fetch_acc = (state_q == S_IDLE) & bus.core_req;
    assign addr_oor  = (bus.core_addr >> ADDR_W) != '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.prog_start) begin
                    ptr_d   = bus.prog_base;
                    rem_d   = bus.prog_len;
                    state_d = (bus.prog_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.prog_wvalid) begin
                    ptr_d = ptr_q + PTR_ONE;
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= fetch_acc;
            err_q   <= fetch_acc & addr_oor;
            if (fetch_acc) begin
                data_q <= addr_oor ? '0 : mem[bus.core_addr[ADDR_W-1:0]];
            end
        end
    end

`ifdef NRISC_IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (wr_en) begin
            sum_q <= sum_q + bus.prog_wdata;
        end
    end

    assign bus.prog_sum = sum_q;
`else
    assign bus.prog_sum = '0;
`endif

    assign bus.core_stall  = bus.core_req & (state_q != S_IDLE);
    assign bus.core_valid  = valid_q;
    assign bus.core_data   = data_q;
    assign bus.core_err    = err_q;
    assign bus.prog_wready = (state_q == S_LOAD);
    assign bus.prog_busy   = (state_q != S_IDLE);
    assign bus.prog_done   = (state_q == S_DONE);
endmodule

// File: tb/tb_nrisc_imem_loader.sv
// Self-checking bench for nrisc_imem_loader: fetch scoreboard, burst loads, wrap, stall, abort.
module tb_nrisc_imem_loader;
    logic clk;
    logic rst;
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   done_cnt = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
        bit          care;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] wq[$];
    logic [15:0] model_mem [0:1023];
    bit          model_known [0:1023];
    logic [15:0] last_sum = '0;

    nrisc_imem_loader_if #(.DATA_W(16), .ADDR_W(10), .CORE_AW(16)) bus ();

    nrisc_imem_loader #(.DATA_W(16), .ADDR_W(10), .CORE_AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] addr);
        exp_t e;
        e.cyc = cyc_cnt + 1;
        if (addr[15:10] != 6'd0) begin
            e.err  = 1'b1;
            e.data = 16'h0000;
            e.care = 1'b1;
        end else begin
            e.err  = 1'b0;
            e.data = model_mem[addr[9:0]];
            e.care = model_known[addr[9:0]];
        end
        sbq.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.prog_done === 1'b1) done_cnt++;
            if (bus.core_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_unexpected_valid: cycle %0d data=%h err=%b, required no valid",
                             cyc_cnt, bus.core_data, bus.core_err);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc_cnt || bus.core_err !== e.err ||
                        (e.care && bus.core_data !== e.data)) begin
                        errors++;
                        $display("FAIL fetch_result: cycle %0d data=%h err=%b, required cycle %0d data=%h err=%b",
                                 cyc_cnt, bus.core_data, bus.core_err, e.cyc, e.data, e.err);
                    end
                end
            end else if (bus.core_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL fetch_valid_x: cycle %0d valid=%b, required 0/1", cyc_cnt, bus.core_valid);
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc_cnt) begin
                checks++;
                errors++;
                e = sbq.pop_front();
                $display("FAIL fetch_missing_valid: cycle %0d valid=0, required valid at cycle %0d", cyc_cnt, e.cyc);
            end
        end
    endtask

    task automatic fetch_seq(input logic [15:0] addrs[$]);
        foreach (addrs[i]) begin
            bus.core_req  = 1'b1;
            bus.core_addr = addrs[i];
            push_exp(addrs[i]);
            tick();
        end
        bus.core_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_load(input logic [9:0] base, input logic [10:0] len, input bit gaps,
                           input bit fetch_during, input logic [15:0] faddr, input int abort_after);
        int          d0;
        logic [15:0] sum;
        logic [9:0]  ptr;
        d0  = done_cnt;
        sum = '0;
        ptr = base;
        checks++;
        if (bus.prog_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_idle_busy: busy=%b, required 0", bus.prog_busy);
        end
        bus.prog_start = 1'b1;
        bus.prog_base  = base;
        bus.prog_len   = len;
        if (fetch_during) begin
            bus.core_req  = 1'b1;
            bus.core_addr = faddr;
            push_exp(faddr);
        end
        tick();
        bus.prog_start = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            if (abort_after == i) begin
                rst              = 1'b0;
                bus.prog_wvalid  = 1'b0;
                bus.core_req     = 1'b0;
                tick();
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if (bus.prog_busy !== 1'b0 || bus.prog_wready !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: busy=%b wready=%b, required 0 0", bus.prog_busy, bus.prog_wready);
                end
                tick();
                checks++;
                if (done_cnt != d0) begin
                    errors++;
                    $display("FAIL abort_no_done: done pulses=%0d, required 0", done_cnt - d0);
                end
                return;
            end
            if (gaps && (i % 2 == 0)) begin
                bus.prog_wvalid = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.prog_wready !== 1'b1 || bus.prog_busy !== 1'b1 ||
                    (fetch_during && bus.core_stall !== 1'b1)) begin
                    errors++;
                    $display("FAIL load_gap: wready=%b busy=%b stall=%b, required 1 1 %b",
                             bus.prog_wready, bus.prog_busy, bus.core_stall, fetch_during);
                end
                tick();
            end
            bus.prog_wvalid = 1'b1;
            bus.prog_wdata  = wq[i];
            @(negedge clk);
            checks++;
            if (bus.prog_wready !== 1'b1 || (fetch_during && bus.core_stall !== 1'b1)) begin
                errors++;
                $display("FAIL load_word%0d: wready=%b stall=%b, required 1 %b",
                         i, bus.prog_wready, bus.core_stall, fetch_during);
            end
            tick();
            model_mem[ptr]   = wq[i];
            model_known[ptr] = 1'b1;
            sum              = sum + wq[i];
            ptr              = ptr + 10'd1;
        end
        bus.prog_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.prog_done !== 1'b1 || bus.prog_wready !== 1'b0 || bus.prog_busy !== 1'b1 ||
            (fetch_during && bus.core_stall !== 1'b1)) begin
            errors++;
            $display("FAIL load_done_state: done=%b wready=%b busy=%b stall=%b, required 1 0 1 %b",
                     bus.prog_done, bus.prog_wready, bus.prog_busy, bus.core_stall, fetch_during);
        end
        tick();
        if (fetch_during) push_exp(faddr);
`ifdef NRISC_IMEM_CHECKSUM_EN
        last_sum = sum;
`else
        last_sum = 16'h0000;
`endif
        @(negedge clk);
        checks++;
        if (bus.prog_busy !== 1'b0 || bus.prog_done !== 1'b0 || done_cnt != d0 + 1 ||
            bus.core_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_complete: busy=%b done=%b pulses=%0d stall=%b, required 0 0 1 0",
                     bus.prog_busy, bus.prog_done, done_cnt - d0, bus.core_stall);
        end
        checks++;
        if (bus.prog_sum !== last_sum) begin
            errors++;
            $display("FAIL load_checksum: sum=%h, required %h", bus.prog_sum, last_sum);
        end
        tick();
        bus.core_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.core_req  = 1'b1;
        bus.core_addr = 16'h0005;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (bus.core_valid !== 1'b0 || bus.core_data !== 16'h0000 || bus.core_err !== 1'b0 ||
            bus.prog_busy !== 1'b0 || bus.prog_wready !== 1'b0 || bus.prog_done !== 1'b0 ||
            bus.prog_sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h err=%b busy=%b wready=%b done=%b sum=%h, required all 0",
                     bus.core_valid, bus.core_data, bus.core_err, bus.prog_busy, bus.prog_wready,
                     bus.prog_done, bus.prog_sum);
        end
        tick();
        rst = 1'b1;
        push_exp(16'h0005);
        tick();
        bus.core_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic_load();
        logic [15:0] a[$];
        wq = '{16'h1111, 16'h2222, 16'h3333};
        do_load(10'h010, 11'd3, 1'b1, 1'b0, 16'h0000, -1);
        a = '{16'h0010, 16'h0011, 16'h0012};
        fetch_seq(a);
    endtask

    task automatic test_wrap();
        logic [15:0] a[$];
        wq = '{16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0};
        do_load(10'h3FE, 11'd4, 1'b0, 1'b0, 16'h0000, -1);
        a = '{16'h03FE, 16'h03FF, 16'h0000, 16'h0001};
        fetch_seq(a);
    endtask

    task automatic test_stall();
        wq = '{16'hAAAA, 16'h5555};
        do_load(10'h010, 11'd2, 1'b1, 1'b1, 16'h0010, -1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a[$];
        a = '{16'h0012, 16'h0400, 16'h0010, 16'hFFFF, 16'h0011};
        fetch_seq(a);
    endtask

    task automatic test_zero_len();
        logic [15:0] a[$];
        wq = {};
        do_load(10'h011, 11'd0, 1'b0, 1'b0, 16'h0000, -1);
        a = '{16'h0011, 16'h0012};
        fetch_seq(a);
    endtask

    task automatic test_abort();
        logic [15:0] a[$];
        wq = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        do_load(10'h020, 11'd4, 1'b0, 1'b0, 16'h0000, -1);
        wq = '{16'hE1E1, 16'hE2E2, 16'hE3E3, 16'hE4E4};
        do_load(10'h020, 11'd4, 1'b0, 1'b0, 16'h0000, 2);
        a = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
        fetch_seq(a);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        rst             = 1'b0;
        bus.core_req    = 1'b0;
        bus.core_addr   = '0;
        bus.prog_start  = 1'b0;
        bus.prog_base   = '0;
        bus.prog_len    = '0;
        bus.prog_wvalid = 1'b0;
        bus.prog_wdata  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic_load();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_zero_len();
        test_abort();
        repeat (3) tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nrisc_imem_loader.md
Name: nrisc_imem_loader

Overview:
- Next-generation NRISC instruction memory: parametrised width/depth synchronous RAM.
- Core fetch port with a request/valid handshake and out-of-range detection.
- Programming port that loads a block of words through a burst-load FSM: base address, word count, valid/ready stream.
- Sits between the core fetch stage and the programmer/bootloader; the core is stalled while a load is in progress.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 10, memory address width; depth = 2^ADDR_W words.
- CORE_AW, 16, width of the core fetch address (TAM).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- core_req  in  1  fetch request, sampled each cycle.
- core_addr  in  CORE_AW  fetch word address.
- core_stall  out  1  fetch not accepted this cycle (load in progress).
- core_valid  out  1  core_data/core_err valid.
- core_data  out  DATA_W  fetched instruction word.
- core_err  out  1  fetched address was out of range.
- prog_start  in  1  start a load (accepted only in IDLE).
- prog_base  in  ADDR_W  first word address of the load.
- prog_len  in  ADDR_W+1  number of words, 0..2^ADDR_W.
- prog_wvalid  in  1  prog_wdata valid.
- prog_wdata  in  DATA_W  word to write.
- prog_wready  out  1  loader accepts a word this cycle.
- prog_busy  out  1  FSM not IDLE.
- prog_done  out  1  one-cycle pulse at load completion.
- prog_sum  out  DATA_W  load checksum (see Optional Feature).

Behaviour:
- Reset: on rst==0 at a clock edge, FSM=IDLE and the word counter clears. All outputs are 0: core_data, core_valid, core_err, prog_wready, prog_busy, prog_done, prog_sum. RAM contents are preserved.
- FSM has three states:
  - IDLE: prog_start=1 latches prog_base into the write pointer and prog_len into the remaining count. If prog_len==0, go to DONE; otherwise go to LOAD.
  - LOAD: prog_wready=1. Each cycle with prog_wvalid=1, write prog_wdata at the pointer, increment the pointer and decrement the remaining count. The pointer wraps modulo 2^ADDR_W (base 0x3FE, len 4 writes 0x3FE, 0x3FF, 0x000, 0x001). Go to DONE when the last word is accepted.
  - DONE: prog_done=1 for exactly one cycle, then return to IDLE. prog_busy=1 in LOAD and DONE.
- prog_start is ignored outside IDLE.
- Fetch acceptance: a fetch is accepted when core_req=1 and FSM==IDLE. core_stall = core_req & (FSM!=IDLE).
- Fetch latency: 1 cycle. core_valid=1 on the cycle after acceptance, otherwise 0.
- Fetch data: core_data = RAM[core_addr[ADDR_W-1:0]].
- Out of range: if any core_addr bit at ADDR_W or above is set, core_err=1 and core_data=0.
- Same-cycle start and fetch: the fetch issued in the IDLE cycle where prog_start is accepted completes normally (valid next cycle). Writes begin the following cycle.
- Read-during-write cannot occur, because fetches are blocked in LOAD.
- Reset mid-LOAD: the FSM aborts to IDLE, words already written remain, no prog_done pulse is generated, and core_valid is cleared.
- core_data holds its last value when core_valid=0, except on reset.

Optional Feature:
- Macro: NRISC_IMEM_CHECKSUM_EN.
- Defined: prog_sum clears to 0 when a load is accepted, then accumulates the sum of every accepted prog_wdata modulo 2^DATA_W. It is stable from the prog_done pulse until the next accepted prog_start.
- Undefined: prog_sum is constant 0 and no adder is built.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with core_req=1 -> core_valid=0, core_data=0, prog_busy=0. Release rst -> the first fetch returns valid 1 cycle later.
- Load base=0x010, len=3 with data 0x1111/0x2222/0x3333 and wvalid gaps -> prog_wready=1 only in LOAD, a single prog_done pulse, and fetches of 0x10..0x12 return those words. With checksum enabled, prog_sum=0x6666.
- Wrap load base=0x3FE, len=4 with data A,B,C,D -> fetching 0x3FE, 0x3FF, 0x000, 0x001 returns A, B, C, D.
- Fetch during LOAD (core_req=1, addr 0x010) -> core_stall=1 and core_valid=0 for the whole load. After DONE the fetch is accepted and valid arrives 1 cycle later.
- Out of range: core_addr=0x0400 -> core_valid=1, core_err=1, core_data=0. Zero-length load (len=0) -> DONE directly, one prog_done pulse, and no RAM write.
- Reset mid-load: base=0x020, len=4, rst=0 after 2 words -> FSM=IDLE, no prog_done. Addresses 0x20 and 0x21 hold the new data, and 0x22 is unchanged.
